// File: rtl/buffer_access_arbiter_if.sv
// rtl/buffer_access_arbiter_if.sv - buffer port bundle between the access arbiter and the bank memory
`ifndef N_PE
`define N_PE 4
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif
`ifndef WID_RAM
`define WID_RAM 8
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 8
`endif

interface buffer_access_arbiter_if #(
   parameter int N_PE        = `N_PE,
   parameter int ADDR_RAM    = `ADDR_RAM,
   parameter int WID_RAM     = `WID_RAM,
   parameter int WID_PE_BITS = `WID_PE_BITS
);
   logic                        mode;
   logic [N_PE-1:0]             m0_r_en;
   logic [ADDR_RAM-1:0]         m0_r_addr;
   logic [N_PE-1:0]             m0_w_en;
   logic [ADDR_RAM-1:0]         m0_w_addr;
   logic [WID_RAM-1:0]          m0_w_data;
   logic [WID_RAM*N_PE-1:0]     m0_r_data;
   logic                        m1_r_en;
   logic [ADDR_RAM-1:0]         m1_r_addr;
   logic                        m1_w_en;
   logic [ADDR_RAM-1:0]         m1_w_addr;
   logic [WID_PE_BITS*N_PE-1:0] m1_input_bus;
   logic [WID_PE_BITS*N_PE-1:0] m1_output_bus;

   modport master (
      output mode, m0_r_en, m0_r_addr, m0_w_en, m0_w_addr, m0_w_data,
      output m1_r_en, m1_r_addr, m1_w_en, m1_w_addr, m1_input_bus,
      input  m0_r_data, m1_output_bus
   );

   modport slave (
      input  mode, m0_r_en, m0_r_addr, m0_w_en, m0_w_addr, m0_w_data,
      input  m1_r_en, m1_r_addr, m1_w_en, m1_w_addr, m1_input_bus,
      output m0_r_data, m1_output_bus
   );
endinterface

// File: rtl/buffer_access_arbiter.sv
// rtl/buffer_access_arbiter.sv - burst arbiter between loader (per-bank port) and PE engine (wide port)
`ifndef N_PE
`define N_PE 4
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif
`ifndef WID_RAM
`define WID_RAM 8
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 8
`endif

module buffer_access_arbiter #(
   parameter int N_PE        = `N_PE,
   parameter int ADDR_RAM    = `ADDR_RAM,
   parameter int WID_RAM     = `WID_RAM,
   parameter int WID_PE_BITS = `WID_PE_BITS,
   parameter int MAX_BURST   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ld_req,
   input  logic                        ld_we,
   input  logic [$clog2(N_PE)-1:0]     ld_bank,
   input  logic [ADDR_RAM-1:0]         ld_addr,
   input  logic [WID_RAM-1:0]          ld_wdata,
   output logic                        ld_gnt,
   output logic                        ld_rvalid,
   output logic [WID_RAM-1:0]          ld_rdata,
   input  logic                        pe_req,
   input  logic                        pe_we,
   input  logic [ADDR_RAM-1:0]         pe_addr,
   input  logic [WID_PE_BITS*N_PE-1:0] pe_wdata,
   output logic                        pe_gnt,
   output logic                        pe_rvalid,
   output logic [WID_PE_BITS*N_PE-1:0] pe_rdata,
   buffer_access_arbiter_if.master     bif
);
   localparam int BANK_W = $clog2(N_PE);
   localparam int CNT_W  = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic              ld_rvalid_q, ld_rvalid_d;
   logic [BANK_W-1:0] ld_rbank_q, ld_rbank_d;
   logic              pe_rvalid_q, pe_rvalid_d;
   logic              ld_acc, pe_acc;
   logic [N_PE-1:0]   bank_onehot;

   assign ld_gnt = (state_q == OWN0);
   assign pe_gnt = (state_q == OWN1);
   assign ld_acc = ld_req & ld_gnt;
   assign pe_acc = pe_req & pe_gnt;

   // Ownership FSM: the burst limit is judged on the post-access count so the MAX_BURST-th access is the last one
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      burst_cnt_d = burst_cnt_q;
      if ((ld_acc || pe_acc) && (burst_cnt_q != MAX_CNT))
         burst_cnt_d = burst_cnt_q + CNT_W'(1);
      case (state_q)
         IDLE: begin
            if (ld_req) begin
               state_d     = OWN0;
               mode_d      = 1'b0;
               burst_cnt_d = '0;
            end else if (pe_req) begin
               state_d     = OWN1;
               mode_d      = 1'b1;
               burst_cnt_d = '0;
            end
         end
         OWN0: if (pe_req && ((burst_cnt_d == MAX_CNT) || !ld_acc)) state_d = TURN;
         OWN1: if (ld_req && ((burst_cnt_d == MAX_CNT) || !pe_acc)) state_d = TURN;
         TURN: begin
            burst_cnt_d = '0;
            state_d     = mode_q ? OWN0 : OWN1;
            mode_d      = ~mode_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Buffer strobes, addresses and data are driven only for the access actually taking place
   always_comb begin
      bank_onehot          = '0;
      bank_onehot[ld_bank] = 1'b1;
      bif.m0_w_en      = (ld_acc &&  ld_we) ? bank_onehot : '0;
      bif.m0_r_en      = (ld_acc && !ld_we) ? bank_onehot : '0;
      bif.m0_w_addr    = (ld_acc &&  ld_we) ? ld_addr : '0;
      bif.m0_w_data    = (ld_acc &&  ld_we) ? ld_wdata : '0;
      bif.m0_r_addr    = (ld_acc && !ld_we) ? ld_addr : '0;
      bif.m1_w_en      = pe_acc &&  pe_we;
      bif.m1_r_en      = pe_acc && !pe_we;
      bif.m1_w_addr    = (pe_acc &&  pe_we) ? pe_addr : '0;
      bif.m1_input_bus = (pe_acc &&  pe_we) ? pe_wdata : '0;
      bif.m1_r_addr    = (pe_acc && !pe_we) ? pe_addr : '0;
   end

   // Read-return bookkeeping: remember which bank the loader read so the right lane is returned
   always_comb begin
      ld_rvalid_d = ld_acc && !ld_we;
      ld_rbank_d  = ld_rvalid_d ? ld_bank : ld_rbank_q;
      pe_rvalid_d = pe_acc && !pe_we;
   end

   // State and return registers; reset drops any read still in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         burst_cnt_q <= '0;
         ld_rvalid_q <= 1'b0;
         ld_rbank_q  <= '0;
         pe_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         burst_cnt_q <= burst_cnt_d;
         ld_rvalid_q <= ld_rvalid_d;
         ld_rbank_q  <= ld_rbank_d;
         pe_rvalid_q <= pe_rvalid_d;
      end
   end

   assign bif.mode  = mode_q;
   assign ld_rvalid = ld_rvalid_q;
   assign pe_rvalid = pe_rvalid_q;
   assign ld_rdata  = ld_rvalid_q ? bif.m0_r_data[ld_rbank_q*WID_RAM +: WID_RAM] : '0;
   assign pe_rdata  = pe_rvalid_q ? bif.m1_output_bus : '0;
endmodule
